// File: rtl/usi_csr_master_if.sv
// ============================================================================
//  Module      : usi_csr_master_if
//  Description : Command/response handshake and USI bus signals of the CSR
//                master, bundled with master (DUT) and slave (driver) views.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface usi_csr_master_if #(
   parameter int pBusAdrsBit = 32
);
   // command channel
   logic                   iCmdValid;
   logic                   oCmdReady;
   logic                   iCmdWrite;
   logic [pBusAdrsBit-1:0] iCmdAdrs;
   logic [31:0]            iCmdWd;
   // USI bus
   logic [31:0]            oMUsiWd;
   logic [pBusAdrsBit-1:0] oMUsiAdrs;
   logic                   oMUsiWCke;
   logic [31:0]            iMUsiRd;
   logic                   iMUsiREd;
   // response channel
   logic                   oRspValid;
   logic                   iRspReady;
   logic [31:0]            oRspRd;
   logic                   oRspWrite;
   logic                   oRspErr;
   logic                   oBusy;

   modport master (
      input  iCmdValid, iCmdWrite, iCmdAdrs, iCmdWd,
      output oCmdReady,
      output oMUsiWd, oMUsiAdrs, oMUsiWCke,
      input  iMUsiRd, iMUsiREd,
      output oRspValid, oRspRd, oRspWrite, oRspErr, oBusy,
      input  iRspReady
   );

   modport slave (
      output iCmdValid, iCmdWrite, iCmdAdrs, iCmdWd,
      input  oCmdReady,
      input  oMUsiWd, oMUsiAdrs, oMUsiWCke,
      output iMUsiRd, iMUsiREd,
      input  oRspValid, oRspRd, oRspWrite, oRspErr, oBusy,
      output iRspReady
   );
endinterface

`default_nettype wire

// File: rtl/usi_csr_master.sv
// ============================================================================
//  Module      : usi_csr_master
//  Description : Single-outstanding CSR master. Turns a valid/ready command
//                into one USI write pulse or an addressed read with timeout,
//                then holds a response until it is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usi_csr_master #(
   parameter int pBusAdrsBit   = 32,
   parameter int pTimeout      = 255,
   parameter int pTimeoutWidth = 8
) (
   input  wire logic          iSysClk,
   input  wire logic          iSysRstn,
   usi_csr_master_if.master   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR    = 3'd1,
      RSET  = 3'd2,
      RWAIT = 3'd3,
      RESP  = 3'd4
   } state_t;

   // last counter value before a read is declared failed
   localparam logic [pTimeoutWidth-1:0] tmo_last = pTimeoutWidth'(pTimeout - 1);

   state_t                   state, state_nxt;
   logic [pTimeoutWidth-1:0] cnt, cnt_nxt;
   logic [pBusAdrsBit-1:0]   adrs_q, adrs_nxt;
   logic [31:0]              wd_q, wd_nxt;
   logic                     wcke_q, wcke_nxt;
   logic                     valid_q, valid_nxt;
   logic [31:0]              rd_q, rd_nxt;
   logic                     rspwr_q, rspwr_nxt;
   logic                     err_q, err_nxt;

   // Next state plus the values every registered output takes in that state.
   // The address register doubles as the latched command address, and the
   // write-data register holds the latched data only for the WR cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      adrs_nxt  = adrs_q;
      wd_nxt    = 32'd0;
      wcke_nxt  = 1'b0;
      valid_nxt = valid_q;
      rd_nxt    = rd_q;
      rspwr_nxt = rspwr_q;
      err_nxt   = err_q;
      case (state)
         IDLE: begin
            if (bus.iCmdValid) begin
               adrs_nxt = bus.iCmdAdrs;
               if (bus.iCmdWrite) begin
                  state_nxt = WR;
                  wcke_nxt  = 1'b1;
                  wd_nxt    = bus.iCmdWd;
               end else begin
                  state_nxt = RSET;
               end
            end
         end
         WR: begin
            // posted write: respond without any slave acknowledgement
            state_nxt = RESP;
            valid_nxt = 1'b1;
            rd_nxt    = 32'd0;
            rspwr_nxt = 1'b1;
            err_nxt   = 1'b0;
         end
         RSET: begin
            // read-valid here still refers to the previous address
            state_nxt = RWAIT;
            cnt_nxt   = '0;
         end
         RWAIT: begin
            if (bus.iMUsiREd) begin
               state_nxt = RESP;
               valid_nxt = 1'b1;
               rd_nxt    = bus.iMUsiRd;
               rspwr_nxt = 1'b0;
               err_nxt   = 1'b0;
            end else if (cnt == tmo_last) begin
               state_nxt = RESP;
               valid_nxt = 1'b1;
               rd_nxt    = 32'd0;
               rspwr_nxt = 1'b0;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RESP: begin
            if (bus.iRspReady) begin
               state_nxt = IDLE;
               valid_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge iSysClk or negedge iSysRstn) begin
      if (!iSysRstn) begin
         state   <= IDLE;
         cnt     <= '0;
         adrs_q  <= '0;
         wd_q    <= 32'd0;
         wcke_q  <= 1'b0;
         valid_q <= 1'b0;
         rd_q    <= 32'd0;
         rspwr_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         adrs_q  <= adrs_nxt;
         wd_q    <= wd_nxt;
         wcke_q  <= wcke_nxt;
         valid_q <= valid_nxt;
         rd_q    <= rd_nxt;
         rspwr_q <= rspwr_nxt;
         err_q   <= err_nxt;
      end
   end

   assign bus.oCmdReady = (state == IDLE);
   assign bus.oBusy     = (state != IDLE);
   assign bus.oMUsiAdrs = adrs_q;
   assign bus.oMUsiWd   = wd_q;
   assign bus.oMUsiWCke = wcke_q;
   assign bus.oRspValid = valid_q;
   assign bus.oRspRd    = rd_q;
   assign bus.oRspWrite = rspwr_q;
   assign bus.oRspErr   = err_q;

endmodule

`default_nettype wire

// File: doc/usi_csr_master.md
USI_CSR_MASTER -- requirements
Module: usi_csr_master

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning), one per line:
- pBusAdrsBit, 32, USI bus address width.
- pTimeout, 255, maximum RWAIT cycles before a read is declared failed (range 1 to 2^pTimeoutWidth-1).
- pTimeoutWidth, 8, timeout counter width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- iSysClk, in, 1, system clock; the only clock.
- iSysRstn, in, 1, reset, asynchronous, active-low.
- iCmdValid, in, 1, command request.
- oCmdReady, out, 1, command accept.
- iCmdWrite, in, 1, 1 = write, 0 = read.
- iCmdAdrs, in, pBusAdrsBit, target address.
- iCmdWd, in, 32, write data.
- oMUsiWd, out, 32, bus write data.
- oMUsiAdrs, out, pBusAdrsBit, bus read/write address.
- oMUsiWCke, out, 1, bus write enable.
- iMUsiRd, in, 32, slave read data.
- iMUsiREd, in, 1, slave read valid.
- oRspValid, out, 1, response valid.
- iRspReady, in, 1, response accept.
- oRspRd, out, 32, read data.
- oRspWrite, out, 1, response belongs to a write.
- oRspErr, out, 1, read timeout.
- oBusy, out, 1, state is not IDLE.
REQ-003 There SHALL be one clock (iSysClk); reset (iSysRstn) SHALL be asynchronous and active-low.
REQ-004 All outputs except oCmdReady and oBusy SHALL be driven directly from flops.
REQ-005 oCmdReady and oBusy SHALL be decoded from the state register only.

Function
REQ-006 The FSM SHALL have the states IDLE, WR, RSET, RWAIT and RESP.
REQ-007 oCmdReady SHALL be 1 only in IDLE; a command is accepted in cycle T when iCmdValid & oCmdReady.
REQ-008 On acceptance, iCmdWrite, iCmdAdrs and iCmdWd SHALL be latched.
REQ-009 On acceptance the next state SHALL be WR if iCmdWrite=1, else RSET.
REQ-010 In WR (cycle T+1):
- oMUsiWCke=1 for exactly one cycle.
- oMUsiAdrs = latched address; oMUsiWd = latched data.
- Next state RESP.
REQ-011 The write response (T+2) SHALL be oRspValid=1, oRspWrite=1, oRspErr=0, oRspRd=0; writes are posted and carry no slave acknowledgement.
REQ-012 In RSET (T+1):
- oMUsiAdrs = latched address; oMUsiWd=0; oMUsiWCke=0.
- iMUsiREd SHALL be ignored in RSET (stale from the previous address).
- The timeout counter SHALL clear; next state RWAIT.
REQ-013 In RWAIT, iMUsiREd=1 SHALL capture iMUsiRd into oRspRd, set oRspErr=0 and oRspWrite=0, and move to RESP.
REQ-014 In RWAIT, iMUsiREd=0 SHALL increment the counter.
REQ-015 When the counter equals pTimeout-1 with iMUsiREd=0, the FSM SHALL go to RESP with oRspErr=1 and oRspRd=0.
REQ-016 If iMUsiREd=1 in the same cycle as the timeout terminal count, the data SHALL win (oRspErr=0).
REQ-017 In RESP, oRspValid SHALL be held at 1 with oRspRd, oRspWrite and oRspErr stable until iRspReady=1.
REQ-018 On the iRspReady=1 cycle the FSM SHALL return to IDLE, and oRspValid SHALL be 0 the following cycle.
REQ-019 A new command SHALL NOT be accepted in the same cycle as response acceptance.
REQ-020 Minimum occupancy SHALL be 3 cycles per write and 4 cycles per read, with iRspReady held at 1.
REQ-021 oMUsiAdrs SHALL hold its last value in IDLE and RESP.
REQ-022 oMUsiWd SHALL be 0 in every state except WR.
REQ-023 oMUsiWCke SHALL be 1 only in WR.
REQ-024 Command inputs SHALL be ignored outside IDLE, and latched values SHALL NOT change.
REQ-025 iRspReady SHALL be ignored outside RESP.

Reset
REQ-026 On iSysRstn=0, immediately and independent of iSysClk, the following SHALL hold:
- state = IDLE.
- oMUsiWCke=0, oMUsiWd=0, oMUsiAdrs=0.
- oRspValid=0, oRspRd=0, oRspWrite=0, oRspErr=0.
- Timeout counter = 0.
REQ-027 While in reset, oCmdReady SHALL be 1 and oBusy SHALL be 0 (decoded from IDLE).
REQ-028 A reset asserted mid-transaction SHALL drop any in-flight command, cut a WR pulse short and produce no response.
REQ-029 After release, the first iSysClk edge SHALL be able to accept a command.

Verification
REQ-030 Write: command write, adrs 0x00040014, wd 0x00000080 accepted at T -> T+1 oMUsiWCke=1 with that adrs/data. T+2 oRspValid=1, oRspWrite=1, oRspErr=0. WCke is never high for 2 cycles.
REQ-031 Read: command read, adrs 0x00040000; bench slave asserts iMUsiREd at T+2 with iMUsiRd=0x011001E0 -> oRspRd=0x011001E0 and oRspErr=0 at T+3. iMUsiREd held high during RSET is ignored.
REQ-032 Timeout: pTimeout=4, iMUsiREd held at 0 -> 4 RWAIT cycles, then oRspValid=1, oRspErr=1, oRspRd=0.
REQ-033 Timeout/data race: pTimeout=4, iMUsiREd=1 on the 4th RWAIT cycle with iMUsiRd=0x5A -> oRspErr=0, oRspRd=0x5A.
REQ-034 Backpressure: iRspReady=0 for 10 cycles -> response fields stable and oCmdReady=0 throughout; response consumed in exactly one cycle once iRspReady=1.
REQ-035 Reset mid-read: iSysRstn=0 during RWAIT -> outputs zero asynchronously and no response issued. After release, a read of 0x00040028 completes normally.
